// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the program sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_JFETCH = 3'd3,
        S_JLOAD  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Jump condition, taken from the low bits of the jump opcode.
    typedef enum logic [1:0] {
        JK_ALWAYS = 2'd0,
        JK_CY     = 2'd1,
        JK_NCY    = 2'd2
    } jkind_e;

    localparam logic [7:0] OP_ST   = 8'h80;
    localparam logic [7:0] OP_CLRC = 8'h90;
    localparam logic [7:0] OP_JMP  = 8'hA0;
    localparam logic [7:0] OP_JC   = 8'hA1;
    localparam logic [7:0] OP_JNC  = 8'hA2;
    localparam logic [7:0] OP_NOP  = 8'hE0;
    localparam logic [7:0] OP_HALT = 8'hF0;

    localparam int         ALU_W    = 3;
    localparam logic [2:0] ALU_NONE = 3'd0;

    function automatic logic jump_taken(input jkind_e kind, input logic cy);
        case (kind)
            JK_ALWAYS: return 1'b1;
            JK_CY:     return cy;
            JK_NCY:    return !cy;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: instruction word to datapath strobes and flow-control flags.
module seq_decode
    import seq_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [7:0]       instr_i,
    output logic [REG_W-1:0] reg_addr_o,
    output logic [ALU_W-1:0] alu_code_o,
    output logic             reg_ce_o,
    output logic             cy_ce_o,
    output logic             a_ce_o,
    output logic             reset_cy_o,
    output logic             is_jump_o,
    output jkind_e           jkind_o,
    output logic             is_halt_o,
    output logic             is_illegal_o
);

    always_comb begin
        reg_addr_o   = '0;
        alu_code_o   = ALU_NONE;
        reg_ce_o     = 1'b0;
        cy_ce_o      = 1'b0;
        a_ce_o       = 1'b0;
        reset_cy_o   = 1'b0;
        is_jump_o    = 1'b0;
        jkind_o      = JK_ALWAYS;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;

        if (!instr_i[7]) begin
            alu_code_o = instr_i[6:4];
            reg_addr_o = REG_W'(instr_i[3:0]);
            a_ce_o     = 1'b1;
            cy_ce_o    = 1'b1;
        end else if (instr_i[7:4] == OP_ST[7:4]) begin
            reg_addr_o = REG_W'(instr_i[3:0]);
            reg_ce_o   = 1'b1;
        end else begin
            case (instr_i)
                OP_CLRC: reset_cy_o = 1'b1;
                OP_JMP: begin
                    is_jump_o = 1'b1;
                    jkind_o   = JK_ALWAYS;
                end
                OP_JC: begin
                    is_jump_o = 1'b1;
                    jkind_o   = JK_CY;
                end
                OP_JNC: begin
                    is_jump_o = 1'b1;
                    jkind_o   = JK_NCY;
                end
                OP_NOP:  ;
                OP_HALT: is_halt_o = 1'b1;
                default: is_illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pp_sequencer.sv
// Program sequencer: fetches from a 1-cycle-latency ROM, executes ALU/ST/CLRC/jump/halt,
// and drives one-cycle datapath strobes during EXEC.
module pp_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic [7:0]        instr,
    input  logic              cy,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [REG_W-1:0]  RegAddr,
    output logic [2:0]        ALUCode,
    output logic              Reg_CE,
    output logic              CY_CE,
    output logic              A_CE,
    output logic              ResetCY,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              illegal_q, illegal_d;
    jkind_e            jkind_q, jkind_d;

    logic [REG_W-1:0]  dec_reg_addr;
    logic [ALU_W-1:0]  dec_alu_code;
    logic              dec_reg_ce, dec_cy_ce, dec_a_ce, dec_reset_cy;
    logic              dec_is_jump, dec_is_halt, dec_is_illegal;
    jkind_e            dec_jkind;
    logic              exec_en;

    seq_decode #(.REG_W(REG_W)) u_decode (
        .instr_i      (instr),
        .reg_addr_o   (dec_reg_addr),
        .alu_code_o   (dec_alu_code),
        .reg_ce_o     (dec_reg_ce),
        .cy_ce_o      (dec_cy_ce),
        .a_ce_o       (dec_a_ce),
        .reset_cy_o   (dec_reset_cy),
        .is_jump_o    (dec_is_jump),
        .jkind_o      (dec_jkind),
        .is_halt_o    (dec_is_halt),
        .is_illegal_o (dec_is_illegal)
    );

    // Reset masks the strobes in its own cycle, even if the FSM sits in EXEC.
    assign exec_en = (state_q == S_EXEC) && !Reset;

    assign prog_addr = pc_q;
    assign RegAddr   = exec_en ? dec_reg_addr : '0;
    assign ALUCode   = exec_en ? dec_alu_code : ALU_NONE;
    assign Reg_CE    = exec_en && dec_reg_ce;
    assign CY_CE     = exec_en && dec_cy_ce;
    assign A_CE      = exec_en && dec_a_ce;
    assign ResetCY   = exec_en && dec_reset_cy;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                       (state_q == S_JFETCH) || (state_q == S_JLOAD);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        jkind_d   = jkind_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                pc_d = pc_q + ADDR_W'(1);
                if (dec_is_illegal) illegal_d = 1'b1;
                if (dec_is_jump) begin
                    jkind_d = dec_jkind;
                    state_d = S_JFETCH;
                end else if (dec_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = step_mode ? S_IDLE : S_FETCH;
                end
            end
            S_JFETCH: state_d = S_JLOAD;
            // instr now holds the target word fetched from PC during JFETCH.
            S_JLOAD: begin
                pc_d    = jump_taken(jkind_q, cy) ? instr[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                state_d = step_mode ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            illegal_q <= 1'b0;
            jkind_q   <= JK_ALWAYS;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            jkind_q   <= jkind_d;
        end
    end

endmodule

// File: tb/tb_pp_sequencer.sv
// Self-checking bench for pp_sequencer: instruction-level reference model expands each
// program into a per-cycle expected output trace, plus directed spot checks.
module tb_pp_sequencer;

    localparam int AW    = 5;
    localparam int RW    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          Reset, start, step_mode, cy;
    logic [7:0]    instr;
    logic [AW-1:0] prog_addr;
    logic [RW-1:0] RegAddr;
    logic [2:0]    ALUCode;
    logic          Reg_CE, CY_CE, A_CE, ResetCY, busy, halted, illegal;

    pp_sequencer #(.ADDR_W(AW), .REG_W(RW)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .step_mode (step_mode),
        .instr     (instr),
        .cy        (cy),
        .prog_addr (prog_addr),
        .RegAddr   (RegAddr),
        .ALUCode   (ALUCode),
        .Reg_CE    (Reg_CE),
        .CY_CE     (CY_CE),
        .A_CE      (A_CE),
        .ResetCY   (ResetCY),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM, one cycle read latency.
    logic [7:0] rom [DEPTH];
    always @(posedge clk) instr <= rom[prog_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Observed vector: busy[18] halted[17] illegal[16] addr[15:11] RegAddr[10:7]
    // ALUCode[6:4] Reg_CE[3] CY_CE[2] A_CE[1] ResetCY[0]
    function automatic logic [18:0] outvec();
        return {busy, halted, illegal, prog_addr, RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY};
    endfunction

    logic [18:0] exp_q[$];
    logic [18:0] obs[$];
    bit          start_q[$];
    bit          cy_q[$];
    int          cy_mode;

    // 0 = simple single-word, 1 = jump, 2 = halt, 3 = reserved
    function automatic int kind(input logic [7:0] w);
        if (w < 8'h91 || w == 8'hE0) return 0;
        if (w >= 8'hA0 && w <= 8'hA2) return 1;
        if (w == 8'hF0) return 2;
        return 3;
    endfunction

    // {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY} expected while an instruction executes
    function automatic logic [10:0] exec_fields(input logic [7:0] w);
        if (w < 8'h80) return {w[3:0], w[6:4], 4'b0110};
        if (w < 8'h90) return {w[3:0], 3'd0, 4'b1000};
        if (w == 8'h90) return {4'd0, 3'd0, 4'b0001};
        return '0;
    endfunction

    function automatic bit pick_cy();
        if (cy_mode == 0) return bit'($urandom_range(0, 1));
        return cy_mode == 2;
    endfunction

    task automatic push(input bit b, input bit h, input bit il, input int addr,
                        input logic [10:0] f, input bit st, input bit c);
        exp_q.push_back({b, h, il, AW'(addr), f});
        start_q.push_back(st);
        cy_q.push_back(c);
    endtask

    // Reference model: walk the program instruction by instruction, emitting the cycles each takes.
    // restart: 0 = stay halted, 1 = always restart from HALT, 2 = random choice.
    task automatic gen(input bit step, input int cmode, input int restart, input int maxc);
        int pc, npc, n;
        bit il, done, c, taken;
        logic [7:0] w;
        exp_q.delete(); start_q.delete(); cy_q.delete();
        cy_mode = cmode;
        pc = 0; il = 0; done = 0;
        push(0, 0, 0, 0, '0, 1, pick_cy());
        while (!done && exp_q.size() < maxc) begin
            w = rom[pc];
            push(1, 0, il, pc, '0, bit'($urandom_range(0, 1)), pick_cy());
            push(1, 0, il, pc, exec_fields(w), bit'($urandom_range(0, 1)), pick_cy());
            if (kind(w) == 3) il = 1;
            if (kind(w) == 1) begin
                npc = (pc + 1) % DEPTH;
                push(1, 0, il, npc, '0, bit'($urandom_range(0, 1)), pick_cy());
                c = pick_cy();
                push(1, 0, il, npc, '0, bit'($urandom_range(0, 1)), c);
                taken = (w == 8'hA0) || (w == 8'hA1 && c) || (w == 8'hA2 && !c);
                pc = taken ? int'(rom[npc]) % DEPTH : (npc + 1) % DEPTH;
            end else begin
                pc = (pc + 1) % DEPTH;
            end
            if (kind(w) == 2) begin
                if (restart == 0 || (restart == 2 && $urandom_range(0, 1) == 0)) begin
                    repeat (3) push(0, 1, il, pc, '0, 0, pick_cy());
                    done = 1;
                end else begin
                    n = (restart == 1) ? 0 : int'($urandom_range(0, 2));
                    repeat (n) push(0, 1, il, pc, '0, 0, pick_cy());
                    push(0, 1, il, pc, '0, 1, pick_cy());
                    pc = 0; il = 0;
                end
            end else if (step) begin
                n = $urandom_range(0, 2);
                repeat (n) push(0, 0, il, pc, '0, 0, pick_cy());
                push(0, 0, il, pc, '0, 1, pick_cy());
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1; start = 0; cy = 0;
        @(negedge clk);
        Reset = 0;
    endtask

    task automatic run(input string name, input bit step);
        logic [18:0] v;
        obs.delete();
        step_mode = step;
        do_reset();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            start = start_q[k];
            cy    = cy_q[k];
            #1;
            v = outvec();
            obs.push_back(v);
            check($sformatf("%s_cyc%0d", name, k), 32'(v), 32'(exp_q[k]));
        end
        @(negedge clk);
        start = 0;
    endtask

    task automatic tick(input bit st, input bit rst, output logic [18:0] v);
        @(negedge clk);
        start = st; Reset = rst; cy = 0;
        #1;
        v = outvec();
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < DEPTH; i++) rom[i] = val;
    endtask

    task automatic random_rom();
        logic [7:0] bad [8];
        int r;
        bad = '{8'h91, 8'hA3, 8'hB0, 8'hC5, 8'hD2, 8'hE1, 8'hF1, 8'hFF};
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      rom[i] = {1'b0, 7'($urandom)};
            else if (r < 45) rom[i] = {4'h8, 4'($urandom)};
            else if (r < 50) rom[i] = 8'h90;
            else if (r < 60) rom[i] = 8'hE0;
            else if (r < 85) rom[i] = 8'hA0 + 8'($urandom_range(0, 2));
            else if (r < 90) rom[i] = 8'hF0;
            else             rom[i] = bad[$urandom_range(0, 7)];
        end
    endtask

    initial begin
        logic [18:0] v;
        int cnt;
        Reset = 1; start = 0; step_mode = 0; cy = 0;
        fill_rom(8'hE0);
        repeat (2) @(negedge clk);

        // ALU op then HALT
        fill_rom(8'hE0); rom[0] = 8'h13; rom[1] = 8'hF0;
        gen(0, 0, 0, 12); run("alu", 0);
        check("alu_exec", 32'(obs[2][10:0]), 32'({4'd3, 3'd1, 4'b0110}));
        check("alu_halt", 32'({obs[5][17], obs[5][15:11]}), 32'({1'b1, 5'd2}));

        // Unconditional jump to 7, then ST r5
        fill_rom(8'hE0); rom[0] = 8'hA0; rom[1] = 8'h07; rom[7] = 8'h85; rom[8] = 8'hF0;
        gen(0, 0, 0, 14); run("jmp", 0);
        check("jmp_pc", 32'(obs[5][15:11]), 32'd7);
        check("jmp_st", 32'(obs[6][10:0]), 32'({4'd5, 3'd0, 4'b1000}));

        // JC not taken / taken
        fill_rom(8'hE0); rom[0] = 8'hA1; rom[1] = 8'h09;
        gen(0, 1, 0, 8); run("jc0", 0);
        check("jc0_pc", 32'(obs[5][15:11]), 32'd2);
        gen(0, 2, 0, 8); run("jc1", 0);
        check("jc1_pc", 32'(obs[5][15:11]), 32'd9);

        // Single-step: one A_CE per start pulse
        fill_rom(8'hE0); rom[0] = 8'h21; rom[1] = 8'h32; rom[2] = 8'h45; rom[3] = 8'hF0;
        gen(1, 0, 0, 40); run("step", 1);
        cnt = 0;
        foreach (obs[k]) if (obs[k][1]) cnt++;
        check("step_ace_count", 32'(cnt), 32'd3);

        // Jump at last address: target word at address 0
        fill_rom(8'hE0); rom[0] = 8'h04; rom[31] = 8'hA0;
        gen(0, 0, 0, 72); run("wrapj", 0);
        check("wrapj_tgtaddr", 32'(obs[65][15:11]), 32'd0);
        check("wrapj_pc", 32'(obs[67][15:11]), 32'd4);

        // NOP run wrapping 31 -> 0
        fill_rom(8'hE0);
        gen(0, 0, 0, 70); run("wrapn", 0);
        check("wrapn_31", 32'(obs[64][15:11]), 32'd31);
        check("wrapn_0", 32'(obs[65][15:11]), 32'd0);

        // Reset during JFETCH
        fill_rom(8'hE0); rom[0] = 8'hA0; rom[1] = 8'h05;
        step_mode = 0; do_reset();
        tick(1, 0, v); tick(0, 0, v); tick(0, 0, v);
        tick(0, 1, v);
        check("rstj_jfetch", 32'({v[18], v[15:11]}), 32'({1'b1, 5'd1}));
        tick(0, 0, v);
        check("rstj_after", 32'(v), 32'd0);

        // Reset during EXEC suppresses strobes
        fill_rom(8'hE0); rom[0] = 8'h13;
        do_reset();
        tick(1, 0, v); tick(0, 0, v);
        tick(0, 1, v);
        check("rste_strobes", 32'(v[10:0]), 32'd0);
        tick(0, 0, v);
        check("rste_after", 32'(v), 32'd0);
        Reset = 0;

        // Reserved opcode: sticky illegal, no strobe, cleared by restart from HALT
        fill_rom(8'hE0); rom[0] = 8'h91; rom[1] = 8'hF0;
        gen(0, 0, 1, 9); run("ill", 0);
        check("ill_nostrobe", 32'(obs[2][10:0]), 32'd0);
        check("ill_set", 32'(obs[3][16]), 32'd1);
        check("ill_clear", 32'({obs[6][16], obs[6][15:11]}), 32'd0);

        // Randomized programs against the reference model
        for (int t = 0; t < 25; t++) begin
            bit s;
            random_rom();
            s = bit'($urandom_range(0, 1));
            gen(s, 0, 2, 80);
            run($sformatf("rnd%0d", t), s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
